// File: rtl/gameconsole_pkg.sv
// Shared video-memory map constants and region encoding used by the cpu bus
// target, the address decoder and the ppu side.
package gameconsole_pkg;

  localparam logic [7:0] VRAM_BASE = 8'h06;

  localparam int PARAM_WORDS = 660;
  localparam int MAP_WORDS   = 2048;
  localparam int TILE_WORDS  = 16384;
  localparam int PAL_WORDS   = 512;

  localparam logic [3:0] SEL_PAR = 4'h0;
  localparam logic [3:0] SEL_MAP = 4'h1;
  localparam logic [3:0] SEL_TIL = 4'h2;
  localparam logic [3:0] SEL_PAL = 4'h3;

  // Offsets inside the tile and palette windows, shared with the ppu fetchers.
  localparam logic [19:0] TILE_SP_BASE = 20'h00000;
  localparam logic [19:0] TILE_BG_BASE = 20'h10000;
  localparam logic [8:0]  PAL_BG_BASE  = 9'h000;
  localparam logic [8:0]  PAL_SP_BASE  = 9'h100;

  typedef enum logic [2:0] {
    RGN_PAR,
    RGN_MAP,
    RGN_TIL,
    RGN_PAL,
    RGN_NONE
  } region_t;

endpackage

// File: rtl/vram_addr_decode.sv
// Combinational decode of a cpu word address into a video region and the
// local word address used by that region's RAM.
module vram_addr_decode
  import gameconsole_pkg::*;
(
  input  logic [31:0] addr,
  output logic [2:0]  region,
  output logic [14:0] local_addr,
  output logic        valid
);

  logic [3:0]  sel;
  logic [19:0] off;
  region_t     rgn;

  assign sel = addr[23:20];
  assign off = addr[19:0];

  // Tile window holds two 16K banks 64K words apart; the gap between them is unmapped.
  always_comb begin
    rgn        = RGN_NONE;
    local_addr = '0;
    if (addr[31:24] == VRAM_BASE) begin
      case (sel)
        SEL_PAR: if (off < 20'(PARAM_WORDS)) begin
          rgn        = RGN_PAR;
          local_addr = {5'b0, off[9:0]};
        end
        SEL_MAP: if (off < 20'(MAP_WORDS)) begin
          rgn        = RGN_MAP;
          local_addr = {4'b0, off[10:0]};
        end
        SEL_TIL: if (off[19:17] == 3'b000 && off[15:14] == 2'b00) begin
          rgn        = RGN_TIL;
          local_addr = {off[16], off[13:0]};
        end
        SEL_PAL: if (off < 20'(PAL_WORDS)) begin
          rgn        = RGN_PAL;
          local_addr = {6'b0, off[8:0]};
        end
        default: ;
      endcase
    end
  end

  assign region = rgn;
  assign valid  = (rgn != RGN_NONE);

endmodule

// File: rtl/vram_bus_target.sv
// Cpu memory-bus responder for the video window: registered region strobes,
// 3-cycle pipelined reads, sticky decode error and per-frame write count.
module vram_bus_target
  import gameconsole_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync,
  input  logic        mem_en,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_din,
  output logic [31:0] mem_dout,
  output logic        mem_rvalid,
  output logic        mem_err,
  output logic [31:0] err_addr,
  input  logic        err_clr,
  output logic [15:0] frame_wr,
  output logic        par_en,
  output logic        par_we,
  output logic [9:0]  par_addr,
  output logic [31:0] par_wdata,
  input  logic [31:0] par_rdata,
  output logic        map_en,
  output logic        map_we,
  output logic [10:0] map_addr,
  output logic [31:0] map_wdata,
  input  logic [31:0] map_rdata,
  output logic        til_en,
  output logic        til_we,
  output logic [14:0] til_addr,
  output logic [31:0] til_wdata,
  input  logic [31:0] til_rdata,
  output logic        pal_en,
  output logic        pal_we,
  output logic [8:0]  pal_addr,
  output logic [31:0] pal_wdata,
  input  logic [31:0] pal_rdata
);

  logic [2:0]  dec_region;
  logic [14:0] dec_addr;
  logic        dec_valid;
  region_t     dec_rgn;

  vram_addr_decode u_decode (
    .addr       (mem_addr),
    .region     (dec_region),
    .local_addr (dec_addr),
    .valid      (dec_valid)
  );

  assign dec_rgn = region_t'(dec_region);

  logic hit_par, hit_map, hit_til, hit_pal;
  logic wr_mapped, rd_req, err_set;

  assign hit_par   = mem_en && dec_rgn == RGN_PAR;
  assign hit_map   = mem_en && dec_rgn == RGN_MAP;
  assign hit_til   = mem_en && dec_rgn == RGN_TIL;
  assign hit_pal   = mem_en && dec_rgn == RGN_PAL;
  assign wr_mapped = mem_en && mem_we && dec_valid;
  assign rd_req    = mem_en && !mem_we;
  assign err_set   = mem_en && !dec_valid;

  // Address and data hold their last value when a region is idle; only en/we pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_en <= 1'b0; par_we <= 1'b0; par_addr <= '0; par_wdata <= '0;
      map_en <= 1'b0; map_we <= 1'b0; map_addr <= '0; map_wdata <= '0;
      til_en <= 1'b0; til_we <= 1'b0; til_addr <= '0; til_wdata <= '0;
      pal_en <= 1'b0; pal_we <= 1'b0; pal_addr <= '0; pal_wdata <= '0;
    end else begin
      par_en <= hit_par;
      par_we <= hit_par && mem_we;
      map_en <= hit_map;
      map_we <= hit_map && mem_we;
      til_en <= hit_til;
      til_we <= hit_til && mem_we;
      pal_en <= hit_pal;
      pal_we <= hit_pal && mem_we;
      if (hit_par) begin
        par_addr  <= dec_addr[9:0];
        par_wdata <= mem_din;
      end
      if (hit_map) begin
        map_addr  <= dec_addr[10:0];
        map_wdata <= mem_din;
      end
      if (hit_til) begin
        til_addr  <= dec_addr;
        til_wdata <= mem_din;
      end
      if (hit_pal) begin
        pal_addr  <= dec_addr[8:0];
        pal_wdata <= mem_din;
      end
    end
  end

  logic        rd_v1, rd_v2;
  region_t     rd_rgn1, rd_rgn2;
  logic [31:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    case (rd_rgn2)
      RGN_PAR: rd_mux = par_rdata;
      RGN_MAP: rd_mux = map_rdata;
      RGN_TIL: rd_mux = til_rdata;
      RGN_PAL: rd_mux = pal_rdata;
      default: rd_mux = '0;
    endcase
  end

  // Unmapped reads still travel the pipe so they answer with zero at the same latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_v1      <= 1'b0;
      rd_v2      <= 1'b0;
      rd_rgn1    <= RGN_NONE;
      rd_rgn2    <= RGN_NONE;
      mem_rvalid <= 1'b0;
      mem_dout   <= '0;
    end else begin
      rd_v1      <= rd_req;
      rd_rgn1    <= dec_rgn;
      rd_v2      <= rd_v1;
      rd_rgn2    <= rd_rgn1;
      mem_rvalid <= rd_v2;
      if (rd_v2)
        mem_dout <= rd_mux;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_err  <= 1'b0;
      err_addr <= '0;
    end else if (err_set) begin
      mem_err  <= 1'b1;
      err_addr <= mem_addr;
    end else if (err_clr) begin
      mem_err  <= 1'b0;
    end
  end

  logic        prev_vsync;
  logic [15:0] wr_count;

  // A write landing on the vsync edge belongs to the frame that just started.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_vsync <= 1'b0;
      wr_count   <= '0;
      frame_wr   <= '0;
    end else begin
      prev_vsync <= vsync;
      if (vsync && !prev_vsync) begin
        frame_wr <= wr_count;
        wr_count <= wr_mapped ? 16'd1 : 16'd0;
      end else if (wr_mapped && wr_count != 16'hFFFF) begin
        wr_count <= wr_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_vram_bus_target.sv
// Directed bench for vram_bus_target with behavioural sync-read region RAMs.
module tb_vram_bus_target;

  logic        clk = 1'b0;
  logic        rst, vsync, mem_en, mem_we, err_clr;
  logic [31:0] mem_addr, mem_din, mem_dout, err_addr;
  logic        mem_rvalid, mem_err;
  logic [15:0] frame_wr;
  logic        par_en, par_we, map_en, map_we, til_en, til_we, pal_en, pal_we;
  logic [9:0]  par_addr;
  logic [10:0] map_addr;
  logic [14:0] til_addr;
  logic [8:0]  pal_addr;
  logic [31:0] par_wdata, map_wdata, til_wdata, pal_wdata;
  logic [31:0] par_rdata, map_rdata, til_rdata, pal_rdata;

  logic [31:0] par_mem [0:1023];
  logic [31:0] map_mem [0:2047];
  logic [31:0] til_mem [0:32767];
  logic [31:0] pal_mem [0:511];

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  vram_bus_target dut (
    .clk(clk), .rst(rst), .vsync(vsync),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_rvalid(mem_rvalid), .mem_err(mem_err),
    .err_addr(err_addr), .err_clr(err_clr), .frame_wr(frame_wr),
    .par_en(par_en), .par_we(par_we), .par_addr(par_addr), .par_wdata(par_wdata), .par_rdata(par_rdata),
    .map_en(map_en), .map_we(map_we), .map_addr(map_addr), .map_wdata(map_wdata), .map_rdata(map_rdata),
    .til_en(til_en), .til_we(til_we), .til_addr(til_addr), .til_wdata(til_wdata), .til_rdata(til_rdata),
    .pal_en(pal_en), .pal_we(pal_we), .pal_addr(pal_addr), .pal_wdata(pal_wdata), .pal_rdata(pal_rdata)
  );

  // Region RAMs: write-first ordering across cycles, data out one cycle after en.
  always @(posedge clk) begin
    if (par_en) begin
      if (par_we) par_mem[par_addr] <= par_wdata;
      else        par_rdata <= par_mem[par_addr];
    end
    if (map_en) begin
      if (map_we) map_mem[map_addr] <= map_wdata;
      else        map_rdata <= map_mem[map_addr];
    end
    if (til_en) begin
      if (til_we) til_mem[til_addr] <= til_wdata;
      else        til_rdata <= til_mem[til_addr];
    end
    if (pal_en) begin
      if (pal_we) pal_mem[pal_addr] <= pal_wdata;
      else        pal_rdata <= pal_mem[pal_addr];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected)
      passes++;
    else
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
  endtask

  task automatic applyStimulus(input logic en, input logic we, input logic [31:0] addr, input logic [31:0] din);
    mem_en   = en;
    mem_we   = we;
    mem_addr = addr;
    mem_din  = din;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; vsync = 1'b0; err_clr = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    tick; tick;
    checkOutput("reset_rvalid", 32'(mem_rvalid), 32'h0);
    checkOutput("reset_dout", mem_dout, 32'h0);
    checkOutput("reset_err", 32'(mem_err), 32'h0);
    checkOutput("reset_frame_wr", 32'(frame_wr), 32'h0);
    checkOutput("reset_par_en", 32'(par_en), 32'h0);
    rst = 1'b0;

    // Param write and the param window boundary.
    applyStimulus(1'b1, 1'b1, 32'h0600_0000, 32'h8000_1414);
    tick; applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("par_en", 32'(par_en), 32'h1);
    checkOutput("par_we", 32'(par_we), 32'h1);
    checkOutput("par_addr", 32'(par_addr), 32'h0);
    checkOutput("par_wdata", par_wdata, 32'h8000_1414);
    checkOutput("par_map_en", 32'(map_en), 32'h0);
    checkOutput("par_no_err", 32'(mem_err), 32'h0);
    tick;
    checkOutput("par_en_one_cycle", 32'(par_en), 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h0600_0293, 32'h1111_1111);
    tick; applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("par_last_en", 32'(par_en), 32'h1);
    checkOutput("par_last_addr", 32'(par_addr), 32'h293);
    applyStimulus(1'b1, 1'b1, 32'h0600_0294, 32'h2222_2222);
    tick; applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("par_over_en", 32'(par_en), 32'h0);
    checkOutput("par_over_err", 32'(mem_err), 32'h1);
    checkOutput("par_over_err_addr", err_addr, 32'h0600_0294);
    err_clr = 1'b1; tick; err_clr = 1'b0;
    checkOutput("par_over_clr", 32'(mem_err), 32'h0);

    // Tile bank1 write then read of the same word on the next cycle.
    applyStimulus(1'b1, 1'b1, 32'h0621_0040, 32'h0000_0040);
    tick; applyStimulus(1'b1, 1'b0, 32'h0621_0040, 32'h0);
    checkOutput("til_wr_en", 32'(til_en), 32'h1);
    checkOutput("til_wr_we", 32'(til_we), 32'h1);
    checkOutput("til_wr_addr", 32'(til_addr), 32'h4040);
    checkOutput("til_wr_data", til_wdata, 32'h0000_0040);
    tick; applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("til_rd_en", 32'(til_en), 32'h1);
    checkOutput("til_rd_we", 32'(til_we), 32'h0);
    checkOutput("til_rd_addr", 32'(til_addr), 32'h4040);
    tick;
    checkOutput("til_rvalid_early", 32'(mem_rvalid), 32'h0);
    tick;
    checkOutput("til_rvalid", 32'(mem_rvalid), 32'h1);
    checkOutput("til_rdata", mem_dout, 32'h0000_0040);

    // Palette: four writes, then four back-to-back reads.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 32'h0630_0000 + 32'(i), 32'hA0 + 32'(i));
      tick;
    end
    for (int k = 0; k < 8; k++) begin
      if (k < 4) applyStimulus(1'b1, 1'b0, 32'h0630_0000 + 32'(k), 32'h0);
      else       applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      if (k >= 3 && k <= 6) begin
        checkOutput($sformatf("pal_rvalid_%0d", k), 32'(mem_rvalid), 32'h1);
        checkOutput($sformatf("pal_rdata_%0d", k), mem_dout, 32'hA0 + 32'(k - 3));
      end else begin
        checkOutput($sformatf("pal_rvalid_%0d", k), 32'(mem_rvalid), 32'h0);
      end
      tick;
    end

    // Map overflow, tile gap read, error clear and set-wins.
    applyStimulus(1'b1, 1'b1, 32'h0610_0800, 32'h0000_DEAD);
    tick; applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("map_over_en", 32'(map_en), 32'h0);
    checkOutput("map_over_err", 32'(mem_err), 32'h1);
    checkOutput("map_over_err_addr", err_addr, 32'h0610_0800);
    err_clr = 1'b1; tick; err_clr = 1'b0;
    checkOutput("map_over_clr", 32'(mem_err), 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0620_4000, 32'h0);
    tick; applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("til_gap_en", 32'(til_en), 32'h0);
    checkOutput("til_gap_err", 32'(mem_err), 32'h1);
    tick; tick;
    checkOutput("unmapped_rvalid", 32'(mem_rvalid), 32'h1);
    checkOutput("unmapped_rdata", mem_dout, 32'h0);
    err_clr = 1'b1; tick; err_clr = 1'b0;
    checkOutput("gap_clr", 32'(mem_err), 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h0700_0000, 32'h5);
    err_clr = 1'b1;
    tick; applyStimulus(1'b0, 1'b0, 32'h0, 32'h0); err_clr = 1'b0;
    checkOutput("set_wins_err", 32'(mem_err), 32'h1);
    checkOutput("set_wins_err_addr", err_addr, 32'h0700_0000);

    // Frame statistics: 7 mapped writes so far, then 5 plus one on the edge.
    vsync = 1'b1; tick; vsync = 1'b0;
    checkOutput("frame_wr_first", 32'(frame_wr), 32'd7);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, 32'h0610_0000 + 32'(i), 32'(i));
      tick;
    end
    applyStimulus(1'b1, 1'b1, 32'h0610_0010, 32'h77);
    vsync = 1'b1;
    tick; applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("frame_wr_five", 32'(frame_wr), 32'd5);
    tick;
    checkOutput("frame_wr_held_high", 32'(frame_wr), 32'd5);
    vsync = 1'b0; tick;
    vsync = 1'b1; tick; vsync = 1'b0;
    checkOutput("frame_wr_edge_write", 32'(frame_wr), 32'd1);

    // Reset one cycle after a read drops it.
    applyStimulus(1'b1, 1'b0, 32'h0630_0001, 32'h0);
    tick; applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    tick; tick;
    checkOutput("pre_rst_rdata", mem_dout, 32'hA1);
    applyStimulus(1'b1, 1'b0, 32'h0630_0002, 32'h0);
    tick; applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b1; tick; rst = 1'b0;
    checkOutput("rst_flush_rvalid", 32'(mem_rvalid), 32'h0);
    checkOutput("rst_flush_dout", mem_dout, 32'h0);
    checkOutput("rst_flush_err", 32'(mem_err), 32'h0);
    checkOutput("rst_flush_err_addr", err_addr, 32'h0);
    checkOutput("rst_flush_frame_wr", 32'(frame_wr), 32'h0);
    checkOutput("rst_flush_pal_addr", 32'(pal_addr), 32'h0);
    tick;
    checkOutput("rst_flush_rvalid_t3", 32'(mem_rvalid), 32'h0);
    tick;
    checkOutput("rst_flush_rvalid_t4", 32'(mem_rvalid), 32'h0);
    vsync = 1'b1; tick; vsync = 1'b0;
    checkOutput("rst_wr_count", 32'(frame_wr), 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
